// File: rtl/mips_prog_loader.sv
// Framed byte-stream program loader and register dumper for the MIPS_32 core:
// loads big-endian words into instruction memory, starts the core, then streams R0..R(DUMP_REGS-1) out.
module mips_prog_loader #(
  parameter int          ADDR_W    = 10,
  parameter int          DUMP_REGS = 6,
  parameter logic [7:0]  HDR       = 8'hA5
) (
  input  logic              clk1,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              core_start,
  input  logic              core_halted,
  output logic [4:0]        reg_raddr,
  input  logic [31:0]       reg_rdata,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              busy,
  output logic              err
);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN, S_DATA, S_CSUM, S_START, S_RUN, S_DUMP_RD, S_DUMP_TX
  } state_t;

  localparam logic [4:0]        LAST_REG = 5'(DUMP_REGS - 1);
  localparam logic [ADDR_W-1:0] ONE_ADDR = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t            state;
  logic [7:0]        nlast;
  logic [7:0]        wcnt;
  logic [7:0]        sum;
  logic [1:0]        bcnt;
  logic [23:0]       word_acc;
  logic [23:0]       shreg;
  logic [ADDR_W-1:0] widx;
  logic              rx_acc;
  logic              tx_acc;

  assign rx_acc = rx_valid & rx_ready;
  assign tx_acc = tx_valid & tx_ready;

  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      rx_ready   <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      core_start <= 1'b0;
      reg_raddr  <= '0;
      tx_data    <= '0;
      tx_valid   <= 1'b0;
      busy       <= 1'b0;
      err        <= 1'b0;
      nlast      <= '0;
      wcnt       <= '0;
      sum        <= '0;
      bcnt       <= '0;
      word_acc   <= '0;
      shreg      <= '0;
      widx       <= '0;
    end else begin
      mem_we     <= 1'b0;
      core_start <= 1'b0;
      case (state)
        S_IDLE: begin
          rx_ready <= 1'b1;
          busy     <= 1'b0;
          if (rx_acc && rx_data == HDR) begin
            state <= S_LEN;
            busy  <= 1'b1;
            err   <= 1'b0;
            sum   <= '0;
            widx  <= '0;
            wcnt  <= '0;
            bcnt  <= '0;
          end
        end
        S_LEN: begin
          if (rx_acc) begin
            nlast <= rx_data - 8'd1;
            if (rx_data == 8'd0) begin
              err   <= 1'b1;
              busy  <= 1'b0;
              state <= S_IDLE;
            end else begin
              state <= S_DATA;
            end
          end
        end
        // Bytes arrive MSB first; the write issues the cycle after the 4th byte.
        S_DATA: begin
          if (rx_acc) begin
            sum      <= sum + rx_data;
            word_acc <= {word_acc[15:0], rx_data};
            bcnt     <= bcnt + 2'd1;
            if (bcnt == 2'd3) begin
              mem_we    <= 1'b1;
              mem_addr  <= widx;
              mem_wdata <= {word_acc, rx_data};
              widx      <= widx + ONE_ADDR;
              wcnt      <= wcnt + 8'd1;
              if (wcnt == nlast) state <= S_CSUM;
            end
          end
        end
        S_CSUM: begin
          if (rx_acc) begin
            if (rx_data == sum) begin
              rx_ready   <= 1'b0;
              core_start <= 1'b1;
              state      <= S_START;
            end else begin
              err   <= 1'b1;
              busy  <= 1'b0;
              state <= S_IDLE;
            end
          end
        end
        S_START: state <= S_RUN;
        S_RUN: begin
          if (core_halted) begin
            reg_raddr <= '0;
            state     <= S_DUMP_RD;
          end
        end
        S_DUMP_RD: begin
          tx_data  <= reg_rdata[31:24];
          shreg    <= reg_rdata[23:0];
          tx_valid <= 1'b1;
          bcnt     <= '0;
          state    <= S_DUMP_TX;
        end
        // tx_data/tx_valid only move on an accepted byte, so they hold while stalled.
        S_DUMP_TX: begin
          if (tx_acc) begin
            bcnt <= bcnt + 2'd1;
            if (bcnt == 2'd3) begin
              tx_valid <= 1'b0;
              if (reg_raddr == LAST_REG) begin
                busy     <= 1'b0;
                rx_ready <= 1'b1;
                state    <= S_IDLE;
              end else begin
                reg_raddr <= reg_raddr + 5'd1;
                state     <= S_DUMP_RD;
              end
            end else begin
              tx_data <= shreg[23:16];
              shreg   <= {shreg[15:0], 8'h00};
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_prog_loader.sv
// Directed/randomized bench for mips_prog_loader with a core stub and a frame-level reference model.
module tb_mips_prog_loader;
  localparam int DR = 6;

  logic        clk1 = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic        mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        core_start;
  logic        core_halted = 1'b1;
  logic [4:0]  reg_raddr;
  logic [31:0] reg_rdata;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b1;
  logic        busy;
  logic        err;

  mips_prog_loader #(.ADDR_W(10), .DUMP_REGS(DR), .HDR(8'hA5)) dut (
    .clk1(clk1), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .core_start(core_start),
    .core_halted(core_halted), .reg_raddr(reg_raddr), .reg_rdata(reg_rdata),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy), .err(err)
  );

  always #5 clk1 = ~clk1;

  logic [31:0] regs [32];
  assign reg_rdata = regs[reg_raddr];

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  bit gaps = 0;
  bit bp = 0;
  bit early = 0;
  int hcnt = 0;

  logic [41:0] wr_q [$];
  int          wr_cyc [$];
  logic [7:0]  tx_q [$];
  int          starts = 0;
  int          start_cyc = 0;
  int          txrise_cyc = -1;
  bit          prev_stall = 0;
  bit          prev_valid = 0;
  logic [7:0]  prev_data = 8'h00;
  logic [31:0] fw [$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Observation side: everything sampled on the falling edge.
  always @(negedge clk1) begin
    cyc++;
    if (mem_we) begin
      wr_q.push_back({mem_addr, mem_wdata});
      wr_cyc.push_back(cyc);
    end
    if (core_start) begin
      starts++;
      start_cyc = cyc;
      txrise_cyc = -1;
    end
    if (tx_valid && !prev_valid && txrise_cyc < 0) txrise_cyc = cyc;
    if (!rst && prev_stall) begin
      chk("tx_hold_data", tx_data, prev_data);
      chk("tx_hold_valid", tx_valid, 1);
    end
    if (tx_valid && tx_ready) tx_q.push_back(tx_data);
    prev_stall = tx_valid && !tx_ready && !rst;
    prev_valid = tx_valid;
    prev_data  = tx_data;
  end

  initial begin
    forever begin
      @(posedge clk1);
      #1;
      tx_ready = bp ? ($urandom_range(0, 2) == 0) : 1'b1;
    end
  end

  // Core stub: start clears HALTED, which returns a few cycles later unless held.
  initial begin
    forever begin
      @(negedge clk1);
      if (core_start) begin
        if (!early) begin
          core_halted = 1'b0;
          hcnt = $urandom_range(1, 6);
        end
      end else if (!core_halted && hcnt > 0) begin
        hcnt--;
        if (hcnt == 0) core_halted = 1'b1;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic clear_obs();
    wr_q.delete();
    wr_cyc.delete();
    tx_q.delete();
    starts = 0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    bit acc;
    if (gaps) begin
      repeat ($urandom_range(0, 2)) begin
        rx_valid = 1'b0;
        @(posedge clk1);
        #1;
      end
    end
    rx_data = b;
    rx_valid = 1'b1;
    n = 0;
    acc = 0;
    while (!acc && n < 200) begin
      @(negedge clk1);
      acc = rx_ready;
      @(posedge clk1);
      #1;
      n++;
    end
    rx_valid = 1'b0;
    if (!acc) chk("rx_accept_timeout", n, 0);
  endtask

  task automatic send_frame(input bit good);
    logic [7:0] cs;
    cs = 8'h00;
    send_byte(8'hA5);
    chk("err_clear_on_hdr", err, 0);
    send_byte(8'(fw.size()));
    foreach (fw[i]) begin
      for (int k = 3; k >= 0; k--) begin
        send_byte(fw[i][8*k +: 8]);
        cs = cs + fw[i][8*k +: 8];
      end
    end
    send_byte(good ? cs : cs - 8'd1);
  endtask

  task automatic check_frame(input bit good);
    int n;
    logic [31:0] r;
    n = 0;
    @(negedge clk1);
    while (busy && n < 5000) begin
      @(negedge clk1);
      n++;
    end
    @(posedge clk1);
    #1;
    chk("done_in_time", n < 5000, 1);
    chk("wr_count", wr_q.size(), fw.size());
    foreach (fw[i]) begin
      if (i < wr_q.size()) begin
        chk("wr_addr", wr_q[i][41:32], i);
        chk("wr_data", wr_q[i][31:0], fw[i]);
      end
    end
    chk("start_count", starts, good ? 1 : 0);
    chk("err_after", err, good ? 0 : 1);
    chk("busy_after", busy, 0);
    chk("rx_ready_after", rx_ready, 1);
    chk("tx_count", tx_q.size(), good ? 4 * DR : 0);
    if (good) begin
      foreach (tx_q[i]) begin
        r = regs[i / 4];
        chk("tx_byte", tx_q[i], r[31 - 8 * (i % 4) -: 8]);
      end
    end
  endtask

  task automatic rand_frame(input int nmax);
    fw.delete();
    repeat ($urandom_range(1, nmax)) fw.push_back($urandom);
    for (int i = 0; i < 32; i++) regs[i] = $urandom;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = 32'h0;
    regs[0] = 32'd0;  regs[1] = 32'd10; regs[2] = 32'd20;
    regs[3] = 32'd25; regs[4] = 32'd30; regs[5] = 32'd55;

    // Reset state
    #3;
    chk("rst_rx_ready", rx_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_core_start", core_start, 0);
    repeat (3) @(posedge clk1);
    #1;
    rst = 1'b0;
    @(posedge clk1);
    #1;
    chk("idle_rx_ready", rx_ready, 1);

    // Nominal load and dump
    fw = '{32'h2801000a, 32'h28020014, 32'h28030019, 32'h0ce77800, 32'h0ce77800,
           32'h00222000, 32'h0ce77800, 32'h00832800, 32'hfc000000};
    clear_obs();
    send_frame(1);
    check_frame(1);
    for (int i = 1; i < wr_cyc.size(); i++) chk("we_spacing", wr_cyc[i] - wr_cyc[i-1], 4);

    // Bad checksum
    clear_obs();
    send_frame(0);
    check_frame(0);

    // Random frame with input gaps; header clears the sticky error
    gaps = 1;
    rand_frame(8);
    clear_obs();
    send_frame(1);
    check_frame(1);
    gaps = 0;

    // Junk then zero count
    clear_obs();
    send_byte(8'h00);
    send_byte(8'hFF);
    send_byte(8'hA5);
    send_byte(8'h00);
    repeat (2) @(posedge clk1);
    #1;
    chk("zero_err", err, 1);
    chk("zero_busy", busy, 0);
    chk("zero_no_we", wr_q.size(), 0);
    chk("zero_no_start", starts, 0);

    // Dump backpressure
    bp = 1;
    rand_frame(6);
    clear_obs();
    send_frame(1);
    check_frame(1);
    bp = 0;

    // Core already halted at start
    early = 1;
    rand_frame(4);
    clear_obs();
    send_frame(1);
    check_frame(1);
    chk("early_dump_latency", txrise_cyc - start_cyc, 3);
    early = 0;

    // Reset after word 4, then full resend
    fw = '{32'h2801000a, 32'h28020014, 32'h28030019, 32'h0ce77800, 32'h0ce77800,
           32'h00222000, 32'h0ce77800, 32'h00832800, 32'hfc000000};
    clear_obs();
    send_byte(8'hA5);
    send_byte(8'h09);
    for (int i = 0; i < 4; i++)
      for (int k = 3; k >= 0; k--) send_byte(fw[i][8*k +: 8]);
    @(posedge clk1);
    #1;
    chk("pre_rst_writes", wr_q.size(), 4);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_rx_ready", rx_ready, 0);
    chk("arst_mem_we", mem_we, 0);
    chk("arst_mem_addr", mem_addr, 0);
    chk("arst_mem_wdata", mem_wdata, 0);
    chk("arst_err", err, 0);
    chk("arst_tx_valid", tx_valid, 0);
    chk("arst_tx_data", tx_data, 0);
    chk("arst_reg_raddr", reg_raddr, 0);
    repeat (3) @(posedge clk1);
    #1;
    rst = 1'b0;
    repeat (2) @(posedge clk1);
    #1;
    chk("no_start_after_abort", starts, 0);
    clear_obs();
    send_frame(1);
    check_frame(1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mips_prog_loader.md
# mips_prog_loader

Hardware program loader and result dumper for the MIPS_32 pipeline, replacing the bench's backdoor memory preload and register readout. It receives a framed byte stream on an 8-bit valid/ready input and writes big-endian 32-bit instruction words into instruction memory from address 0. On a good checksum it pulses `core_start`, waits for the core to halt, then streams registers R0..R(DUMP_REGS-1) out as bytes. It sits between a host byte link (UART/debug shim) and the core's memory write port and register-file read port.

## Interface
- `ADDR_W`, 10: instruction memory word-address width; must be ≥ 8.
- `DUMP_REGS`, 6: number of registers dumped after halt, 1..32.
- `HDR`, 8'hA5: frame header byte.

- `clk1` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `rx_data` in 8: input byte.
- `rx_valid` in 1: input byte valid.
- `rx_ready` out 1: loader accepts a byte when `rx_valid & rx_ready` at a rising edge.
- `mem_we` out 1: instruction memory write strobe, one cycle per word.
- `mem_addr` out ADDR_W: word address.
- `mem_wdata` out 32: instruction word.
- `core_start` out 1: one-cycle pulse; the core clears PC, HALTED and TAKEN_BRANCH.
- `core_halted` in 1: core HALTED flag, level.
- `reg_raddr` out 5: register-file read address.
- `reg_rdata` in 32: combinational register read data for `reg_raddr`.
- `tx_data` out 8: output byte.
- `tx_valid` out 1: output byte valid.
- `tx_ready` in 1: downstream accepts the byte when `tx_valid & tx_ready`.
- `busy` out 1: high in every state except IDLE.
- `err` out 1: sticky frame error.

## Operation
- Frame format: `HDR`, `N` (word count, 1..255), 4·N payload bytes (MSB first per word), then `CSUM` = sum of payload bytes mod 256.
- IDLE: `rx_ready`=1.
  - A byte ≠ `HDR` is discarded.
  - `HDR` → LEN, clears `err`, zeroes the checksum and address counter.
- LEN: stores `N`.
  - `N`=0 → `err`=1, return to IDLE.
  - `N`≠0 → DATA.
- DATA: shifts bytes into a 32-bit assembler and adds each byte to the 8-bit checksum.
  - On the 4th byte of a word, the next cycle has `mem_we`=1, `mem_addr`=word index, `mem_wdata`=assembled word; the word index then increments.
  - After word N-1 → CSUM.
- CSUM: compares the received byte with the running sum.
  - Match → START.
  - Mismatch → `err`=1, IDLE, no `core_start`. Words already written stay in memory.
- START: `core_start`=1 for exactly one cycle → RUN.
- RUN: waits for `core_halted`=1 (sampled at the edge) → DUMP_RD with r=0.
- DUMP_RD: drives `reg_raddr`=r and latches `reg_rdata` into the tx shift register at the edge → DUMP_TX.
- DUMP_TX: emits 4 bytes MSB first.
  - After the 4th accepted byte: if r<DUMP_REGS-1, increment r → DUMP_RD; otherwise → IDLE.
- `rx_ready`=1 only in IDLE, LEN, DATA and CSUM. Bytes presented in other states are not consumed.

## Timing
- Reset values: `rx_ready`=0 while `rst` is high, then 1 in IDLE. `mem_we`, `mem_addr`, `mem_wdata`, `core_start`, `reg_raddr`, `tx_data`, `tx_valid`, `busy`, `err` are all 0. State is IDLE.
- Reset asserted mid-frame, mid-run or mid-dump aborts immediately to IDLE. Memory is not rolled back; no `core_start` is issued.
- Input throughput is 1 byte/cycle with `rx_valid` held high.
- `mem_we` lags the 4th byte's accept edge by one cycle. A word write never coincides with a stall, because the loader keeps accepting bytes. Back-to-back words give `mem_we` every 4 cycles.
- `core_start` fires 1 cycle after the CSUM accept edge. RUN is entered 1 cycle after `core_start`.
- `core_halted` already high in the RUN entry cycle goes to DUMP_RD on the next edge.
- Dump: 1 cycle in DUMP_RD per register.
  - `tx_valid` rises the cycle after.
  - `tx_data` and `tx_valid` are held stable while `tx_valid & !tx_ready`.
  - With `tx_ready` tied high, each register takes 5 cycles.
- `tx_valid` drops in the cycle after the last byte is accepted. `busy` falls in the same cycle.
- The word address wraps mod 2^ADDR_W. This cannot occur, since N ≤ 255 and ADDR_W ≥ 8.

## Test plan
- **Nominal load and dump:** send A5, 09, then the nine words 2801000a 28020014 28030019 0ce77800 0ce77800 00222000 0ce77800 00832800 fc000000, then DF.
  - Required: 9 `mem_we` pulses at addresses 0..8 with exactly those words, one `core_start` pulse, `err`=0.
  - With a core or stub that raises `core_halted` and holds R0..R5 = 0,10,20,25,30,55, `tx` emits 24 bytes: 00000000 0000000a 00000014 00000019 0000001e 00000037.
- **Bad checksum:** same frame with checksum DE → `err`=1, no `core_start`, `busy`=0, back in IDLE.
  - Required: a following good frame clears `err` on its header byte.
- **Zero count and junk:** bytes 00 FF then A5 00 → junk ignored; `err`=1 after the 00 count; no `mem_we`.
- **Backpressure:** `tx_ready` toggling 1-of-3 cycles during the dump → identical 24-byte sequence, with `tx_data` stable while stalled.
- **Input gaps and halted-early:** `rx_valid` deasserted randomly → same memory writes. `core_halted` already high at START → dump begins 2 cycles after `core_start`.
- **Reset mid-operation:** `rst` pulsed after word 4 of the nominal frame, then the full frame resent → outputs return to reset values asynchronously, with no `core_start` before the resend and normal completion afterwards.
